ring_push_framer: RTL and testbench



---
 rtl/ring_framer_pkg.sv | 22 ++
 rtl/ring_push_framer.sv | 136 +++++++++++++
 tb/tb_ring_push_framer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ring_framer_pkg.sv
// Shared types and helpers for ring_push_framer.
// PUSH_FRAMER_LEN_EN adds a length word ahead of the checksum trailer.
package ring_framer_pkg;

  typedef enum logic [2:0] {
    IDLE, OPEN, STREAM, PUSH, TRAILER, COMMIT, ROLLBACK, DRAIN
  } state_t;

`ifdef PUSH_FRAMER_LEN_EN
  localparam int TRAILER_WORDS = 2;
`else
  localparam int TRAILER_WORDS = 1;
`endif

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] top;
    top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ring_push_framer.sv
// Frames a valid/ready word stream into one ring: payload, checksum trailer,
// then commit; errored or oversize packets are rolled back. Macro: PUSH_FRAMER_LEN_EN.
module ring_push_framer
  import ring_framer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int RING_SIZE = 128,
  parameter int USED_W    = 8,
  parameter int MAX_PKT   = 33,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_error,
  output logic              in_ready,
  output logic [DATA_W-1:0] push_data,
  output logic              push_request,
  input  logic              push_done,
  output logic              rc_open,
  output logic              rc_commit,
  output logic              rc_rollback,
  input  logic [USED_W-1:0] rc_used,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int CW   = $clog2(MAX_PKT + 1);
  localparam int NEED = MAX_PKT + 1 + TRAILER_WORDS;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] csum;
  logic              last_q, err_q;
  logic              room;
`ifdef PUSH_FRAMER_LEN_EN
  logic              len_sent;
`endif

  // Space is reserved once per packet so the ring can never fill mid-packet.
  always_comb room = (RING_SIZE - int'(rc_used)) >= NEED;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (in_valid && room) state_nx = OPEN;
      OPEN:     state_nx = STREAM;
      STREAM:   if (in_valid) state_nx = PUSH;
      PUSH:
        if (push_done) begin
          if (err_q)                    state_nx = ROLLBACK;
          else if (last_q)              state_nx = TRAILER;
          else if (cnt == CW'(MAX_PKT)) state_nx = ROLLBACK;
          else                          state_nx = STREAM;
        end
      TRAILER:
`ifdef PUSH_FRAMER_LEN_EN
        if (push_done && len_sent) state_nx = COMMIT;
`else
        if (push_done) state_nx = COMMIT;
`endif
      COMMIT:   state_nx = IDLE;
      ROLLBACK: state_nx = last_q ? IDLE : DRAIN;
      DRAIN:    if (in_valid && in_last) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state == STREAM) || (state == DRAIN);
    push_request = (state == PUSH) || (state == TRAILER);
    rc_open      = (state == OPEN);
    rc_commit    = (state == COMMIT);
    rc_rollback  = (state == ROLLBACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      csum       <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      push_data  <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
`ifdef PUSH_FRAMER_LEN_EN
      len_sent   <= 1'b0;
`endif
    end else begin
      case (state)
        OPEN: begin
          cnt  <= '0;
          csum <= '0;
`ifdef PUSH_FRAMER_LEN_EN
          len_sent <= 1'b0;
`endif
        end
        STREAM:
          if (in_valid) begin
            push_data <= in_data;
            csum      <= csum + in_data;
            cnt       <= cnt + 1'b1;
            last_q    <= in_last;
            err_q     <= in_error;
          end
        // Preload the first trailer word as the last payload word is taken.
        PUSH:
          if (push_done && !err_q && last_q) begin
`ifdef PUSH_FRAMER_LEN_EN
            push_data <= DATA_W'(cnt);
`else
            push_data <= csum;
`endif
          end
`ifdef PUSH_FRAMER_LEN_EN
        TRAILER:
          if (push_done && !len_sent) begin
            push_data <= csum;
            len_sent  <= 1'b1;
          end
`endif
        COMMIT:   pkt_count  <= CNT_W'(sat_inc(32'(pkt_count), CNT_W));
        ROLLBACK: drop_count <= CNT_W'(sat_inc(32'(drop_count), CNT_W));
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_push_framer.sv
// Randomized bench for ring_push_framer against a packet-level reference model.
// Follows PUSH_FRAMER_LEN_EN the same way as the design.
module tb_ring_push_framer;

  localparam int DATA_W    = 16;
  localparam int RING_SIZE = 128;
  localparam int USED_W    = 8;
  localparam int MAX_PKT   = 33;
  localparam int CNT_W     = 8;
`ifdef PUSH_FRAMER_LEN_EN
  localparam int TRL = 2;
`else
  localparam int TRL = 1;
`endif
  localparam int NEED = MAX_PKT + 1 + TRL;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid, in_last, in_error, in_ready;
  logic [DATA_W-1:0] push_data;
  logic              push_request, push_done;
  logic              rc_open, rc_commit, rc_rollback;
  logic [USED_W-1:0] rc_used;
  logic [CNT_W-1:0]  pkt_count, drop_count;

  always #5 clk = ~clk;

  ring_push_framer #(
    .DATA_W(DATA_W), .RING_SIZE(RING_SIZE), .USED_W(USED_W),
    .MAX_PKT(MAX_PKT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_error(in_error), .in_ready(in_ready),
    .push_data(push_data), .push_request(push_request), .push_done(push_done),
    .rc_open(rc_open), .rc_commit(rc_commit), .rc_rollback(rc_rollback),
    .rc_used(rc_used), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  int n_chk = 0, n_bad = 0;
  int opens, commits, rbs, dly;
  int exp_pkt, exp_drop;
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] pk_w[$];
  int pk_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ring-side responder: acks requests after 0..2 idle cycles, records pushed
  // words, counts control pulses, and sometimes pulses push_done unrequested.
  initial begin
    push_done = 1'b0;
    dly = 0;
    opens = 0; commits = 0; rbs = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        push_done = 1'b0;
        dly = 0;
      end else begin
        if (rc_open)     opens++;
        if (rc_commit)   commits++;
        if (rc_rollback) rbs++;
        if (push_done) begin
          push_done = 1'b0;
          dly = $urandom_range(0, 2);
        end else if (push_request) begin
          if (dly == 0) begin
            push_done = 1'b1;
            got_q.push_back(push_data);
          end else dly--;
        end else begin
          push_done = ($urandom_range(0, 7) == 0);
        end
      end
    end
  end

  task automatic put(input logic [DATA_W-1:0] d, input logic l, input logic e);
    int g;
    g = 0;
    in_data = d; in_last = l; in_error = e; in_valid = 1'b1;
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("accept", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_error = 1'b0;
  endtask

  // Model: words are pushed in order until an error word, the last word, or
  // MAX_PKT words; a last word gets the trailer and a commit, else rollback.
  task automatic run_pkt(input string tag);
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] sum;
    int ecommit, erb, n;
    n = pk_w.size();
    sum = '0; ecommit = 0; erb = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pk_w[i]);
      sum = sum + pk_w[i];
      if (i == pk_err) begin erb = 1; break; end
      if (i == n - 1) begin
`ifdef PUSH_FRAMER_LEN_EN
        exp_q.push_back(DATA_W'(i + 1));
`endif
        exp_q.push_back(sum);
        ecommit = 1;
        break;
      end
      if (i + 1 == MAX_PKT) begin erb = 1; break; end
    end
    if (ecommit == 1) exp_pkt  = (exp_pkt  < 255) ? exp_pkt  + 1 : 255;
    if (erb == 1)     exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;

    got_q.delete();
    opens = 0; commits = 0; rbs = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      put(pk_w[i], i == n - 1, i == pk_err);
    end
    repeat (24) @(negedge clk);

    chk({tag, ".npush"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, ".push"}, got_q[i], exp_q[i]);
    chk({tag, ".open"}, opens, 1);
    chk({tag, ".commit"}, commits, ecommit);
    chk({tag, ".rollback"}, rbs, erb);
    chk({tag, ".pkt_count"}, pkt_count, exp_pkt);
    chk({tag, ".drop_count"}, drop_count, exp_drop);
  endtask

  task automatic rand_pkt(input int len, input int err);
    pk_w.delete();
    for (int i = 0; i < len; i++) pk_w.push_back(DATA_W'($urandom));
    pk_err = err;
  endtask

  initial begin
    int g;
    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_error = 1'b0;
    rc_used = '0;
    exp_pkt = 0; exp_drop = 0;
    repeat (3) @(negedge clk);
    chk("rst.in_ready", {31'd0, in_ready}, 0);
    chk("rst.push_request", {31'd0, push_request}, 0);
    chk("rst.push_data", push_data, 0);
    chk("rst.pulses", {29'd0, rc_open, rc_commit, rc_rollback}, 0);
    chk("rst.counts", {pkt_count, drop_count}, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic 3-word packet
    pk_w = '{16'h0001, 16'h0002, 16'h0003}; pk_err = -1;
    run_pkt("s1");
    chk("s1.csum", got_q[got_q.size() - 1], 16'h0006);

    // error on second word, rest drained
    rand_pkt(5, 1);
    run_pkt("s2");

    // oversize, then a normal packet
    rand_pkt(40, -1);
    run_pkt("s3");
    rand_pkt(4, -1);
    run_pkt("s3b");

    // not enough room: stall without opening
    opens = 0;
    rc_used = USED_W'(100);
    in_data = 16'h00AA; in_valid = 1'b1; in_last = 1'b0;
    repeat (10) @(negedge clk);
    chk("s4.stall_ready", {31'd0, in_ready}, 0);
    chk("s4.stall_open", opens, 0);
    rc_used = USED_W'(RING_SIZE - NEED);
    pk_w = '{16'h00AA, 16'h1234}; pk_err = -1;
    run_pkt("s4");
    rc_used = '0;

    // reset mid-STREAM after two pushes
    got_q.delete();
    put(16'h0011, 1'b0, 1'b0);
    put(16'h0022, 1'b0, 1'b0);
    g = 0;
    while (got_q.size() < 2 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("s5.two_pushes", got_q.size(), 2);
    @(negedge clk);
    commits = 0; rbs = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("s5.in_ready", {31'd0, in_ready}, 0);
    chk("s5.push_request", {31'd0, push_request}, 0);
    chk("s5.push_data", push_data, 0);
    chk("s5.counts", {pkt_count, drop_count}, 0);
    rst = 1'b0;
    exp_pkt = 0; exp_drop = 0;
    repeat (2) @(negedge clk);
    chk("s5.no_pulse", commits + rbs, 0);
    pk_w = '{16'h0001, 16'h0002, 16'h0003}; pk_err = -1;
    run_pkt("s5");

    // two-word packet; with the length word the trailer is 0x0002, 0x01FF
    pk_w = '{16'h00FF, 16'h0100}; pk_err = -1;
    run_pkt("s6");
`ifdef PUSH_FRAMER_LEN_EN
    chk("s6.len", got_q[2], 16'h0002);
`endif
    chk("s6.csum", got_q[got_q.size() - 1], 16'h01FF);

    // random traffic, including single-word and exactly MAX_PKT packets
    for (int p = 0; p < 30; p++) begin
      int len, err;
      len = (p == 0) ? 1 : (p == 1) ? MAX_PKT : (p == 2) ? MAX_PKT + 1 : $urandom_range(1, 40);
      err = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      rc_used = USED_W'($urandom_range(0, RING_SIZE - NEED));
      rand_pkt(len, err);
      run_pkt("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
